fb_sdram_arbiter: RTL and testbench

//  Shares the single SDRAM framebuffer master port between two requesters:
//  the LCD pixel-fetch engine (burst reads) and the NIOS/SD image writer (single writes).

---
 rtl/fb_sdram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_fb_sdram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sdram_arbiter.sv
// Two-requester arbiter for the SDRAM framebuffer port: LCD burst reads vs. image-writer single writes.
// Optional statistics counters are enabled with `define FB_ARB_STATS_EN.
module fb_sdram_arbiter #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_W   = 8,
  parameter int unsigned MAX_BURST = 128
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FB_ARB_STATS_EN
  input  logic               stat_clr,
  output logic [31:0]        stat_rd_beats,
  output logic [31:0]        stat_wr_words,
  output logic [15:0]        stat_urgent,
`endif
  input  logic               d_req,
  input  logic               d_urgent,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BURST_W-1:0] d_len,
  output logic               d_gnt,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_rvalid,
  input  logic               w_req,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic [DATA_W-1:0]  w_wdata,
  output logic               w_gnt,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_read,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_wdata,
  output logic [BURST_W-1:0] m_burstcount,
  input  logic               m_waitrequest,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               m_rvalid,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_t;

  state_t               state_q, state_d;
  logic                 last_w_q, last_w_d;
  logic [BURST_W-1:0]   beat_q, beat_d;
  logic [BURST_W-1:0]   len_q, len_d;
  logic [BURST_W-1:0]   len_eff;
  logic                 d_win, w_win;

  logic                 m_read_d, m_write_d;
  logic [ADDR_W-1:0]    m_addr_d;
  logic [DATA_W-1:0]    m_wdata_d;
  logic [BURST_W-1:0]   m_burstcount_d;
  logic [DATA_W-1:0]    d_rdata_d;
  logic                 d_rvalid_d;

  // Zero-length bursts become single reads; long ones are clamped.
  always_comb begin
    if (d_len == '0)
      len_eff = BURST_W'(1);
    else if (d_len > BURST_W'(MAX_BURST))
      len_eff = BURST_W'(MAX_BURST);
    else
      len_eff = d_len;
  end

  // Urgent display wins outright; a contested grant goes opposite to the last winner.
  assign d_win = d_req & (d_urgent | ~w_req | last_w_q);
  assign w_win = w_req & ~d_win;

  // Grants coincide with the slave accepting the command so requesters can retire in the same cycle.
  assign d_gnt = (state_q == RD_CMD) & ~m_waitrequest;
  assign w_gnt = (state_q == WR_CMD) & ~m_waitrequest;
  assign busy  = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    last_w_d       = last_w_q;
    beat_d         = beat_q;
    len_d          = len_q;
    m_read_d       = m_read;
    m_write_d      = m_write;
    m_addr_d       = m_addr;
    m_wdata_d      = m_wdata;
    m_burstcount_d = m_burstcount;
    d_rdata_d      = d_rdata;
    d_rvalid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (d_win) begin
          state_d        = RD_CMD;
          m_read_d       = 1'b1;
          m_addr_d       = d_addr;
          m_burstcount_d = len_eff;
          len_d          = len_eff;
        end else if (w_win) begin
          state_d        = WR_CMD;
          m_write_d      = 1'b1;
          m_addr_d       = w_addr;
          m_wdata_d      = w_wdata;
          m_burstcount_d = BURST_W'(1);
        end
      end
      RD_CMD: begin
        if (!m_waitrequest) begin
          state_d        = RD_DATA;
          last_w_d       = 1'b0;
          m_read_d       = 1'b0;
          m_addr_d       = '0;
          m_burstcount_d = '0;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          d_rdata_d  = m_rdata;
          d_rvalid_d = 1'b1;
          beat_d     = beat_q + BURST_W'(1);
          if (beat_q == len_q - BURST_W'(1))
            state_d = IDLE;
        end
      end
      WR_CMD: begin
        if (!m_waitrequest) begin
          state_d        = IDLE;
          last_w_d       = 1'b1;
          m_write_d      = 1'b0;
          m_addr_d       = '0;
          m_wdata_d      = '0;
          m_burstcount_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_w_q     <= 1'b1;
      beat_q       <= '0;
      len_q        <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_burstcount <= '0;
      d_rdata      <= '0;
      d_rvalid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_w_q     <= last_w_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      m_read       <= m_read_d;
      m_write      <= m_write_d;
      m_addr       <= m_addr_d;
      m_wdata      <= m_wdata_d;
      m_burstcount <= m_burstcount_d;
      d_rdata      <= d_rdata_d;
      d_rvalid     <= d_rvalid_d;
    end
  end

`ifdef FB_ARB_STATS_EN
  // Saturating traffic counters; urgent counts grants decided by the urgent rule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rd_beats <= '0;
      stat_wr_words <= '0;
      stat_urgent   <= '0;
    end else if (stat_clr) begin
      stat_rd_beats <= '0;
      stat_wr_words <= '0;
      stat_urgent   <= '0;
    end else begin
      if ((state_q == RD_DATA) && m_rvalid && (stat_rd_beats != '1))
        stat_rd_beats <= stat_rd_beats + 32'(1);
      if (w_gnt && (stat_wr_words != '1))
        stat_wr_words <= stat_wr_words + 32'(1);
      if ((state_q == IDLE) && d_req && d_urgent && (stat_urgent != '1))
        stat_urgent <= stat_urgent + 16'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Directed bench for fb_sdram_arbiter: transaction vector table plus reset-mid-burst sequence.
module tb_fb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_urgent, w_req;
  logic [24:0] d_addr, w_addr;
  logic [7:0]  d_len;
  logic [15:0] w_wdata;
  logic        d_gnt, d_rvalid, w_gnt;
  logic [15:0] d_rdata;
  logic [24:0] m_addr;
  logic        m_read, m_write;
  logic [15:0] m_wdata;
  logic [7:0]  m_burstcount;
  logic        m_waitrequest, m_rvalid;
  logic [15:0] m_rdata;
  logic        busy;
`ifdef FB_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_rd_beats, stat_wr_words;
  logic [15:0] stat_urgent;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_sdram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
`ifdef FB_ARB_STATS_EN
    .stat_clr      (stat_clr),
    .stat_rd_beats (stat_rd_beats),
    .stat_wr_words (stat_wr_words),
    .stat_urgent   (stat_urgent),
`endif
    .d_req         (d_req),
    .d_urgent      (d_urgent),
    .d_addr        (d_addr),
    .d_len         (d_len),
    .d_gnt         (d_gnt),
    .d_rdata       (d_rdata),
    .d_rvalid      (d_rvalid),
    .w_req         (w_req),
    .w_addr        (w_addr),
    .w_wdata       (w_wdata),
    .w_gnt         (w_gnt),
    .m_addr        (m_addr),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_wdata       (m_wdata),
    .m_burstcount  (m_burstcount),
    .m_waitrequest (m_waitrequest),
    .m_rdata       (m_rdata),
    .m_rvalid      (m_rvalid),
    .busy          (busy)
  );

  typedef struct {
    logic        d_req;
    logic        d_urgent;
    logic        w_req;
    logic [7:0]  d_len;
    logic [24:0] d_addr;
    logic [24:0] w_addr;
    logic [15:0] w_wdata;
    int          wait_cyc;
    logic        exp_rd;
    logic [7:0]  exp_bc;
  } vec_t;

  function automatic vec_t mk(input logic dr, input logic du, input logic wr, input int len,
                              input int da, input int wa, input int wd, input int wt,
                              input logic erd, input int ebc);
    vec_t v;
    v.d_req = dr; v.d_urgent = du; v.w_req = wr; v.d_len = 8'(len);
    v.d_addr = 25'(da); v.w_addr = 25'(wa); v.w_wdata = 16'(wd);
    v.wait_cyc = wt; v.exp_rd = erd; v.exp_bc = 8'(ebc);
    return v;
  endfunction

  function automatic logic [15:0] pat(input int idx, input int k);
    return 16'(idx * 256 + k) ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the arbiter idle; leaves it the same way.
  task automatic run_txn(input int idx, input vec_t v);
    int   cyc, gnts, unstable, beats, bad, len;
    logic [24:0] ea;
    d_req = v.d_req; d_urgent = v.d_urgent; w_req = v.w_req;
    d_len = v.d_len; d_addr = v.d_addr; w_addr = v.w_addr; w_wdata = v.w_wdata;
    m_waitrequest = (v.wait_cyc != 0);
    ea = v.exp_rd ? v.d_addr : v.w_addr;
    @(negedge clk);
    cyc = 1;
    while (!(m_read || m_write) && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    $display("vector %0d", idx);
    check("cmd_latency", 32'(cyc), 32'(1));
    if (!(m_read || m_write)) return;
    check("cmd_kind", 32'({m_read, m_write}), v.exp_rd ? 32'(2) : 32'(1));
    check("burstcount", 32'(m_burstcount), 32'(v.exp_bc));
    check("addr", 32'(m_addr), 32'(ea));
    if (!v.exp_rd) check("wdata", 32'(m_wdata), 32'(v.w_wdata));
    gnts = 0;
    unstable = 0;
    for (int i = 0; i < v.wait_cyc; i++) begin
      #1;
      gnts += int'(d_gnt) + int'(w_gnt);
      @(negedge clk);
      if (m_read !== v.exp_rd || m_write !== !v.exp_rd || m_addr !== ea ||
          m_burstcount !== v.exp_bc || (!v.exp_rd && m_wdata !== v.w_wdata))
        unstable++;
    end
    if (v.wait_cyc > 0) begin
      check("early_gnt", 32'(gnts), 32'(0));
      check("hold_stable", 32'(unstable), 32'(0));
    end
    m_waitrequest = 1'b0;
    #1;
    check("gnt", 32'({d_gnt, w_gnt}), v.exp_rd ? 32'(2) : 32'(1));
    @(negedge clk);
    check("cmd_drop", 32'({m_read, m_write, d_gnt, w_gnt}), 32'(0));
    if (v.exp_rd) begin
      len = int'(v.exp_bc);
      beats = 0;
      bad = 0;
      for (int k = 0; k < len; k++) begin
        if (k > 0 && d_rvalid === 1'b1) begin
          beats++;
          if (d_rdata !== pat(idx, k - 1)) bad++;
        end else if (k > 0 || d_rvalid !== 1'b0) begin
          bad++;
        end
        m_rvalid = 1'b1;
        m_rdata  = pat(idx, k);
        @(negedge clk);
      end
      m_rvalid = 1'b0;
      if (d_rvalid === 1'b1) begin
        beats++;
        if (d_rdata !== pat(idx, len - 1)) bad++;
      end
      check("beats", 32'(beats), 32'(len));
      check("rdata", 32'(bad), 32'(0));
    end
    check("busy_end", 32'(busy), 32'(0));
  endtask

  vec_t vecs[14];

  initial begin
    int rvcnt, bsy;
    // Both held from reset alternate D,W,D,W; then urgency, clamping and waitstates.
    vecs[0]  = mk(1, 0, 1,   4, 'h100, 'h1000, 'h1111, 0, 1,   4);
    vecs[1]  = mk(1, 0, 1,   4, 'h100, 'h1001, 'h2222, 0, 0,   1);
    vecs[2]  = mk(1, 0, 1,   3, 'h180, 'h1002, 'h3333, 0, 1,   3);
    vecs[3]  = mk(1, 0, 1,   3, 'h180, 'h1003, 'h4444, 0, 0,   1);
    vecs[4]  = mk(1, 0, 0,   4, 'h100, 'h0,    'h0,    0, 1,   4);
    vecs[5]  = mk(1, 1, 1,   2, 'h300, 'h1004, 'h5555, 0, 1,   2);
    vecs[6]  = mk(1, 1, 1,   2, 'h302, 'h1004, 'h5555, 0, 1,   2);
    vecs[7]  = mk(1, 0, 1,   2, 'h304, 'h1004, 'h5555, 0, 0,   1);
    vecs[8]  = mk(0, 0, 1,   0, 'h0,   'h1ABCDEF, 'hBEEF, 5, 0, 1);
    vecs[9]  = mk(1, 0, 0,   0, 'h400, 'h0,    'h0,    0, 1,   1);
    vecs[10] = mk(1, 0, 0, 200, 'h500, 'h0,    'h0,    0, 1, 128);
    vecs[11] = mk(1, 0, 0, 255, 'h600, 'h0,    'h0,    0, 1, 128);
    vecs[12] = mk(1, 0, 1,   5, 'h700, 'h1005, 'h6666, 3, 0,   1);
    vecs[13] = mk(1, 0, 0,   1, 'h800, 'h0,    'h0,    2, 1,   1);

    rst = 1'b0;
    d_req = 0; d_urgent = 0; w_req = 0; d_len = 0; d_addr = 0; w_addr = 0; w_wdata = 0;
    m_waitrequest = 0; m_rvalid = 0; m_rdata = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({d_gnt, d_rvalid, w_gnt, m_read, m_write, busy}), 32'(0));
    check("reset_data", 32'({m_addr, m_burstcount}) | 32'({m_wdata, d_rdata}), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'(0));

    for (int i = 0; i < 14; i++) run_txn(i, vecs[i]);

    // Reset in the middle of an 8-beat burst, with beats still arriving afterwards.
    d_req = 1; d_urgent = 0; w_req = 0; d_len = 8; d_addr = 25'h200; m_waitrequest = 0;
    @(negedge clk);
    check("mb_cmd", 32'(m_read), 32'(1));
    d_req = 0;
    @(negedge clk);
    m_rvalid = 1; m_rdata = 16'h1111;
    @(negedge clk);
    m_rdata = 16'h2222;
    @(negedge clk);
    check("mb_beat2", 32'({d_rvalid, d_rdata}), 32'({1'b1, 16'h2222}));
    m_rdata = 16'h3333;
    rst = 1'b0;
    #1;
    check("mb_reset_out", 32'({d_rvalid, d_gnt, w_gnt, m_read, m_write, busy}), 32'(0));
    check("mb_reset_rdata", 32'(d_rdata), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    rvcnt = 0;
    bsy = 0;
    for (int k = 0; k < 6; k++) begin
      m_rdata = m_rdata + 16'(1);
      @(negedge clk);
      rvcnt += int'(d_rvalid);
      bsy += int'(busy);
    end
    m_rvalid = 0;
    check("late_rvalid", 32'(rvcnt), 32'(0));
    check("late_busy", 32'(bsy), 32'(0));
    // Reset restores last grant = W, so a contested request goes to D.
    run_txn(20, mk(1, 0, 1, 2, 'h900, 'h1006, 'h7777, 0, 1, 2));

    d_req = 0; w_req = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
